// File: rtl/key_event_ctrl.sv
// Key event classifier: turns debounced press/release edges into click,
// double-click, long-press and auto-repeat pulses using one shared timer.
module key_event_ctrl #(
    parameter int LONG_CNT   = 50_000_000,
    parameter int GAP_CNT    = 15_000_000,
    parameter int REPEAT_CNT = 10_000_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       click_pulse,
    output logic       dclick_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic [1:0] event_code,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG_HOLD
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_click;
    logic             r_dclick;
    logic             r_long;
    logic             r_repeat;
    logic [1:0]       r_code;

    logic             w_press;
    logic             w_release;
    logic [CNT_W-1:0] w_cntInc;

    // key_state alone is bounce-prone; only flagged edges carry meaning
    assign w_press   = key_flag & ~key_state;
    assign w_release = key_flag &  key_state;
    assign w_cntInc  = r_cnt + CNT_W'(1);

    // Edge events are tested before terminal counts so an edge always wins a tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_click  <= 1'b0;
            r_dclick <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_code   <= 2'b00;
        end else begin
            r_click  <= 1'b0;
            r_dclick <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_press) begin
                            r_state <= PRESS1;
                            r_cnt   <= '0;
                        end
                    end
                    PRESS1: begin
                        if (w_release) begin
                            r_state <= WAIT2;
                            r_cnt   <= '0;
                        end else if (r_cnt == LONG_LAST) begin
                            r_long  <= 1'b1;
                            r_code  <= 2'b11;
                            r_state <= LONG_HOLD;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cntInc;
                        end
                    end
                    WAIT2: begin
                        if (w_press) begin
                            r_state <= PRESS2;
                            r_cnt   <= '0;
                        end else if (r_cnt == GAP_LAST) begin
                            r_click <= 1'b1;
                            r_code  <= 2'b01;
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cntInc;
                        end
                    end
                    PRESS2: begin
                        if (w_release) begin
                            r_dclick <= 1'b1;
                            r_code   <= 2'b10;
                            r_state  <= IDLE;
                            r_cnt    <= '0;
                        end
                    end
                    LONG_HOLD: begin
                        if (w_release) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == REPEAT_LAST) begin
                            r_repeat <= 1'b1;
                            r_cnt    <= '0;
                        end else begin
                            r_cnt <= w_cntInc;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign click_pulse  = r_click;
    assign dclick_pulse = r_dclick;
    assign long_pulse   = r_long;
    assign repeat_pulse = r_repeat;
    assign event_code   = r_code;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench: a timestamp-based key model is compared every cycle,
// plus directed scenarios with hand-computed pulse timings.
module tb_key_event_ctrl;

    localparam int LONG_CNT   = 100;
    localparam int GAP_CNT    = 40;
    localparam int REPEAT_CNT = 20;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       en        = 1'b0;
    logic       key_flag  = 1'b0;
    logic       key_state = 1'b1;
    logic       click_pulse;
    logic       dclick_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic [1:0] event_code;
    logic       busy;

    key_event_ctrl #(
        .LONG_CNT  (LONG_CNT),
        .GAP_CNT   (GAP_CNT),
        .REPEAT_CNT(REPEAT_CNT),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .key_flag    (key_flag),
        .key_state   (key_state),
        .click_pulse (click_pulse),
        .dclick_pulse(dclick_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .event_code  (event_code),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: the key's situation plus the clock time it began, so every
    // timeout is an elapsed-time comparison rather than a running counter.
    typedef enum {M_QUIET, M_FIRST_DOWN, M_AWAIT_SECOND, M_SECOND_DOWN, M_REPEATING} mode_t;
    mode_t      mMode  = M_QUIET;
    int         mT     = 0;
    int         mStart = 0;
    logic [3:0] mEvt   = 4'b0000;
    logic [1:0] mCode  = 2'b00;

    wire mPress   = key_flag && !key_state;
    wire mRelease = key_flag && key_state;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mMode <= M_QUIET;
            mEvt  <= 4'b0000;
            mCode <= 2'b00;
        end else begin
            mT   <= mT + 1;
            mEvt <= 4'b0000;
            if (!en) begin
                mMode <= M_QUIET;
            end else begin
                case (mMode)
                    M_QUIET:
                        if (mPress) begin mMode <= M_FIRST_DOWN; mStart <= mT; end
                    M_FIRST_DOWN:
                        if (mRelease) begin mMode <= M_AWAIT_SECOND; mStart <= mT; end
                        else if (mT - mStart == LONG_CNT) begin
                            mEvt <= 4'b0100; mCode <= 2'b11; mMode <= M_REPEATING; mStart <= mT;
                        end
                    M_AWAIT_SECOND:
                        if (mPress) mMode <= M_SECOND_DOWN;
                        else if (mT - mStart == GAP_CNT) begin
                            mEvt <= 4'b0001; mCode <= 2'b01; mMode <= M_QUIET;
                        end
                    M_SECOND_DOWN:
                        if (mRelease) begin mEvt <= 4'b0010; mCode <= 2'b10; mMode <= M_QUIET; end
                    M_REPEATING:
                        if (mRelease) mMode <= M_QUIET;
                        else if (mT - mStart == REPEAT_CNT) begin mEvt <= 4'b1000; mStart <= mT; end
                    default: mMode <= M_QUIET;
                endcase
            end
        end
    end

    int clickCnt = 0, dclickCnt = 0, longCnt = 0, repeatCnt = 0;
    int clickCyc = -1, dclickCyc = -1, longCyc = -1;
    int repQ[$];

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Compare process and pulse monitor, sampled mid-cycle
    initial forever begin
        logic [3:0] got;
        @(negedge clk);
        got = {repeat_pulse, long_pulse, dclick_pulse, click_pulse};
        tests++;
        if (got !== mEvt || event_code !== mCode || busy !== (mMode != M_QUIET)) begin
            fails++;
            $display("[TB] FAIL model cyc=%0d got pulses=%b code=%b busy=%b, expected pulses=%b code=%b busy=%b",
                     cyc, got, event_code, busy, mEvt, mCode, (mMode != M_QUIET));
        end
        tests++;
        if ($countones(got) > 1) begin
            fails++;
            $display("[TB] FAIL onehot cyc=%0d got pulses=%b, expected at most one high", cyc, got);
        end
        if (click_pulse)  begin clickCnt++;  clickCyc  = cyc; end
        if (dclick_pulse) begin dclickCnt++; dclickCyc = cyc; end
        if (long_pulse)   begin longCnt++;   longCyc   = cyc; end
        if (repeat_pulse) begin repeatCnt++; repQ.push_back(cyc); end
    end

    task automatic applyStimulus(input logic flag, input logic level, output int edgeCyc);
        key_flag  = flag;
        key_state = level;
        @(posedge clk);
        #1;
        key_flag = 1'b0;
        edgeCyc  = cyc;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int p, r, r1, r2, p2, c0, d0, l0, q0;
        logic lvl;
        int enHold;

        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_code", event_code, 0);
        checkOutput("reset_pulses", {repeat_pulse, long_pulse, dclick_pulse, click_pulse}, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        en      = 1'b1;

        // Single click, first press right after reset release
        c0 = clickCnt; d0 = dclickCnt;
        applyStimulus(1'b1, 1'b0, p);
        checkOutput("first_press_busy", busy, 1);
        waitCycles(9);
        applyStimulus(1'b1, 1'b1, r);
        waitCycles(45);
        checkOutput("click_count", clickCnt - c0, 1);
        checkOutput("click_delay", clickCyc - r, 40);
        checkOutput("click_no_dclick", dclickCnt - d0, 0);
        checkOutput("click_code", event_code, 1);
        checkOutput("click_idle", busy, 0);

        // Double click
        c0 = clickCnt; d0 = dclickCnt;
        applyStimulus(1'b1, 1'b0, p);
        waitCycles(4);
        applyStimulus(1'b1, 1'b1, r1);
        waitCycles(14);
        applyStimulus(1'b1, 1'b0, p2);
        checkOutput("dclick_gap", p2 - r1, 15);
        waitCycles(5);
        applyStimulus(1'b1, 1'b1, r2);
        waitCycles(50);
        checkOutput("dclick_count", dclickCnt - d0, 1);
        checkOutput("dclick_delay", dclickCyc - r2, 0);
        checkOutput("dclick_no_click", clickCnt - c0, 0);
        checkOutput("dclick_code", event_code, 2);

        // Long hold with auto-repeat
        l0 = longCnt; q0 = repeatCnt; repQ.delete();
        applyStimulus(1'b1, 1'b0, p);
        waitCycles(164);
        applyStimulus(1'b1, 1'b1, r);
        checkOutput("long_release_at", r - p, 165);
        waitCycles(30);
        checkOutput("long_count", longCnt - l0, 1);
        checkOutput("long_delay", longCyc - p, 100);
        checkOutput("repeat_count", repeatCnt - q0, 3);
        checkOutput("repeat_0", (repQ.size() > 0) ? repQ[0] - p : -1, 120);
        checkOutput("repeat_1", (repQ.size() > 1) ? repQ[1] - p : -1, 140);
        checkOutput("repeat_2", (repQ.size() > 2) ? repQ[2] - p : -1, 160);
        checkOutput("long_code", event_code, 3);
        checkOutput("long_idle", busy, 0);

        // Release on the exact terminal-count cycle of the long timer
        l0 = longCnt; c0 = clickCnt;
        applyStimulus(1'b1, 1'b0, p);
        waitCycles(99);
        applyStimulus(1'b1, 1'b1, r);
        waitCycles(2);
        checkOutput("tie_no_long", longCnt - l0, 0);
        checkOutput("tie_in_wait", busy, 1);
        waitCycles(45);
        checkOutput("tie_click_delay", clickCyc - r, 40);
        checkOutput("tie_click_count", clickCnt - c0, 1);

        // Reset during the double-click gap
        c0 = clickCnt; d0 = dclickCnt; l0 = longCnt;
        applyStimulus(1'b1, 1'b0, p);
        waitCycles(9);
        applyStimulus(1'b1, 1'b1, r);
        waitCycles(10);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_busy_now", busy, 0);
        checkOutput("rst_code_now", event_code, 0);
        waitCycles(2);
        reset_n = 1'b1;
        waitCycles(60);
        checkOutput("rst_no_pulse", (clickCnt - c0) + (dclickCnt - d0) + (longCnt - l0), 0);

        // Enable drop during the first press; key stays held afterwards
        c0 = clickCnt; l0 = longCnt; q0 = repeatCnt;
        applyStimulus(1'b1, 1'b0, p);
        waitCycles(10);
        en = 1'b0;
        waitCycles(1);
        checkOutput("en_busy", busy, 0);
        waitCycles(3);
        en = 1'b1;
        waitCycles(120);
        checkOutput("en_no_pulse", (clickCnt - c0) + (longCnt - l0) + (repeatCnt - q0), 0);
        checkOutput("en_code_held", event_code, 0);
        applyStimulus(1'b1, 1'b1, r);
        waitCycles(60);
        checkOutput("en_stale_release", busy + (clickCnt - c0), 0);

        // Bounce without flags, then a stray press during the first press
        for (int i = 0; i < 10; i++) begin
            key_state = ~key_state;
            waitCycles(1);
        end
        checkOutput("bounce_idle", busy, 0);
        l0 = longCnt;
        applyStimulus(1'b1, 1'b0, p);
        for (int i = 0; i < 20; i++) begin
            key_state = ~key_state;
            waitCycles(1);
        end
        checkOutput("bounce_press1", busy, 1);
        applyStimulus(1'b1, 1'b0, r);
        waitCycles(90);
        checkOutput("stray_press_long", longCyc - p, 100);
        checkOutput("stray_press_count", longCnt - l0, 1);
        applyStimulus(1'b1, 1'b1, r);
        waitCycles(5);

        // Randomised traffic checked only by the model
        lvl = 1'b1;
        enHold = 0;
        for (int i = 0; i < 15000; i++) begin
            int rate;
            rate = ((i / 500) % 2 == 0) ? 8 : 60;
            reset_n = ($urandom_range(0, 1999) != 0);
            if (enHold > 0) begin
                enHold--;
                en = 1'b0;
            end else begin
                en = 1'b1;
                if ($urandom_range(0, 399) == 0) enHold = $urandom_range(1, 6);
            end
            key_flag = ($urandom_range(0, rate - 1) == 0);
            if (key_flag) begin
                key_state = ($urandom_range(0, 6) == 0) ? lvl : ~lvl;
                lvl = key_state;
            end else if ($urandom_range(0, 9) == 0) begin
                key_state = 1'($urandom_range(0, 1));
            end
            waitCycles(1);
        end
        key_flag = 1'b0;
        reset_n  = 1'b1;
        en       = 1'b1;
        waitCycles(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
KEY_EVENT_CTRL -- requirements
Module: key_event_ctrl

Interface
REQ-001 Parameter LONG_CNT, default 50_000_000, hold time in cycles before a long press is declared (1 s at 50 MHz).
REQ-002 Parameter GAP_CNT, default 15_000_000, maximum release gap in cycles for a double click (300 ms).
REQ-003 Parameter REPEAT_CNT, default 10_000_000, auto-repeat interval in cycles while held after a long press (200 ms).
REQ-004 Parameter CNT_W, default 26, width of the shared timing counter; it SHALL hold max(LONG_CNT, GAP_CNT, REPEAT_CNT).
REQ-005 Port clk, input, 1, system clock (50 MHz).
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port en, input, 1, block enable; 0 forces IDLE.
REQ-008 Port key_flag, input, 1, single-cycle pulse from the debounce filter marking a debounced edge.
REQ-009 Port key_state, input, 1, debounced key level: 0 = pressed, 1 = released.
REQ-010 Port click_pulse, output, 1, single-cycle pulse on a single click.
REQ-011 Port dclick_pulse, output, 1, single-cycle pulse on a double click.
REQ-012 Port long_pulse, output, 1, single-cycle pulse when the long-press threshold is reached.
REQ-013 Port repeat_pulse, output, 1, single-cycle auto-repeat pulse during a long hold.
REQ-014 Port event_code, output, 2, last event: 00 none, 01 click, 10 dclick, 11 long.
REQ-015 Port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 The press event SHALL be key_flag=1 with key_state=0; the release event SHALL be key_flag=1 with key_state=1; key_state without key_flag SHALL be ignored.
REQ-017 The FSM states SHALL be IDLE, PRESS1, WAIT2, PRESS2 and LONG_HOLD, with one shared counter cnt.
REQ-018 In IDLE, a press SHALL go to PRESS1 with cnt=0.
REQ-019 In PRESS1, cnt SHALL increment each cycle; a release SHALL go to WAIT2 with cnt=0; cnt==LONG_CNT-1 without a release SHALL assert long_pulse and go to LONG_HOLD with cnt=0.
REQ-020 In WAIT2, cnt SHALL increment; a press SHALL go to PRESS2; cnt==GAP_CNT-1 without a press SHALL assert click_pulse and go to IDLE.
REQ-021 In PRESS2, there SHALL be no timeout; a release SHALL assert dclick_pulse and go to IDLE.
REQ-022 In LONG_HOLD, cnt SHALL increment and wrap to 0 at REPEAT_CNT-1, asserting repeat_pulse on that cycle; a release SHALL go to IDLE with no pulse.
REQ-023 When an edge event and a counter terminal count occur in the same cycle, the edge event SHALL win and no timeout pulse SHALL be emitted.
REQ-024 An edge event of the wrong kind for the current state (for example a press in PRESS1) SHALL be ignored, with no state change and no cnt reset.
REQ-025 All pulses SHALL be registered, asserted exactly one cycle after the deciding clk edge, and at most one pulse output SHALL be high per cycle.
REQ-026 event_code SHALL update in the same cycle as its pulse and hold until the next event.
REQ-027 When en=0, the FSM SHALL go synchronously to IDLE with cnt=0; all pulses SHALL be 0 and event_code SHALL be held.
REQ-028 While en=0, key_flag SHALL be ignored; a key already held when en returns to 1 SHALL produce no event until its next press.

Reset
REQ-029 While reset_n=0, state SHALL be IDLE, cnt=0, all pulses 0, event_code=00 and busy=0, independent of clk.
REQ-030 Reset asserted mid-sequence (any state) SHALL abort it with no pending pulse emitted after release.
REQ-031 After reset_n deasserts, the first press SHALL be accepted on the next clk edge.

Verification
REQ-032 The bench SHALL use LONG_CNT=100, GAP_CNT=40 and REPEAT_CNT=20.
REQ-033 Click: press, release 10 cycles later, no further press -> exactly one click_pulse 40 cycles after release, event_code=01.
REQ-034 Double click: press, release, press 15 cycles after release, release -> dclick_pulse the cycle after the second release, no click_pulse, event_code=10.
REQ-035 Long hold: press held 165 cycles -> long_pulse at cycle 100, repeat_pulse at cycles 120, 140 and 160, then release -> no further pulses, event_code=11.
REQ-036 Tie: release flag on the exact cycle cnt==LONG_CNT-1 -> no long_pulse, and the FSM goes to WAIT2.
REQ-037 Disturbance: reset_n=0 during WAIT2 and, separately, en=0 during PRESS1 -> no pulse; busy=0 within one cycle (immediately for reset).
REQ-038 Bounce rejection: key_state toggles without key_flag -> no state change.
